// File: rtl/gmux_sel_ctrl_if.sv
// Signal bundle between the GMUX select sequencer and its environment
// (request source, muxed-clock consumer, GMUX IS0 pin).
interface gmux_sel_ctrl_if;
  // qreq/qack is a level handshake: qreq rises to ask the consumer to quiesce,
  // qack is honoured only while the sequencer waits for it, and qreq stays high
  // until the select has changed and settled.
  logic req;
  logic qack;
  logic is0;
  logic qreq;
  logic busy;
  logic done;
  logic tout;

  modport master (
    output req,
    output qack,
    input  is0,
    input  qreq,
    input  busy,
    input  done,
    input  tout
  );

  modport slave (
    input  req,
    input  qack,
    output is0,
    output qreq,
    output busy,
    output done,
    output tout
  );
endinterface

// File: rtl/gmux_sel_ctrl.sv
// Sequencer for the GMUX IS0 select: quiesce the consumer, hold off, flip the
// select, let it settle, then release the quiesce request and pulse done.
module gmux_sel_ctrl #(
    parameter int HOLD_CYCLES    = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    gmux_sel_ctrl_if.slave       bus,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        QWAIT  = 3'd1,
        HOLD   = 3'd2,
        SETTLE = 3'd3,
        FIN    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             req_meta, req_s;
    logic             tgt, tgt_nxt;
    logic             is0_q, is0_nxt;
    logic             qreq_q, qreq_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             tout_q, tout_nxt;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    // req may be asynchronous to clk; qack is already in this domain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            tgt      <= 1'b0;
            is0_q    <= 1'b0;
            qreq_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            req_meta <= bus.req;
            req_s    <= req_meta;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tgt      <= tgt_nxt;
            is0_q    <= is0_nxt;
            qreq_q   <= qreq_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            tout_q   <= tout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_s != is0_q)       state_nxt = QWAIT;
            QWAIT:   if (bus.qack || cnt_zero) state_nxt = HOLD;
            HOLD:    if (cnt_zero)             state_nxt = SETTLE;
            SETTLE:  if (cnt_zero)             state_nxt = FIN;
            FIN:                               state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt  = cnt;
        tgt_nxt  = tgt;
        is0_nxt  = is0_q;
        qreq_nxt = qreq_q;
        tout_nxt = tout_q;
        done_nxt = 1'b0;
        busy_nxt = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (req_s != is0_q) begin
                    tgt_nxt  = req_s;
                    qreq_nxt = 1'b1;
                    tout_nxt = 1'b0;
                    cnt_nxt  = TIMEOUT_LD;
                end
            end
            QWAIT: begin
                // An acknowledge on the timeout edge still counts as a clean ack.
                if (bus.qack) begin
                    cnt_nxt = HOLD_LD;
                end else if (cnt_zero) begin
                    tout_nxt = 1'b1;
                    cnt_nxt  = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    is0_nxt = tgt;
                    cnt_nxt = SETTLE_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    qreq_nxt = 1'b0;
                    done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    assign bus.is0   = is0_q;
    assign bus.qreq  = qreq_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.tout  = tout_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// Self-checking bench for gmux_sel_ctrl: latency checks per scenario plus a
// scoreboard of {tout, is0} expected at each done pulse.
module tb_gmux_sel_ctrl;
  localparam int W = 2;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HOLD = 3'd2;

  logic clk;
  logic rstn;
  logic [2:0] state_dbg;
  gmux_sel_ctrl_if bus ();

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic done_prev = 1'b0;

  gmux_sel_ctrl dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got time_expired exp scenario_end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.qreq;
      1:       return bus.is0;
      2:       return bus.done;
      3:       return bus.tout;
      default: return bus.busy;
    endcase
  endfunction

  // Counts clock edges until the selected output reaches val, bounded at 64.
  task automatic wait_sig(input string tag, input int which, input logic val, input int exp_edges);
    int n = 0;
    while (sig(which) !== val && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, exp_edges);
  endtask

  task automatic do_reset(input logic req_val);
    rstn     = 1'b0;
    bus.req  = req_val;
    bus.qack = 1'b0;
    tick(3);
    rstn = 1'b1;
  endtask

  // scoreboard: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rstn && bus.done) begin
      check("done_width", done_prev, 1'b0);
      if (exp_q.size() == 0) begin
        check("done_expected", bus.done, 1'b0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("done_result", {bus.tout, bus.is0}, e);
      end
    end
    done_prev = bus.done;
  end

  initial begin
    rstn     = 1'b0;
    bus.req  = 1'b0;
    bus.qack = 1'b0;

    // reset / idle
    bus.req = 1'b1;
    tick(3);
    check("rst_outputs", {bus.is0, bus.qreq, bus.busy, bus.done, bus.tout}, 5'b0);
    check("rst_state", state_dbg, ST_IDLE);
    bus.req = 1'b0;
    rstn    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("idle_quiet", {bus.is0, bus.qreq, bus.busy}, 3'b000);
    end

    // normal switch, qack three cycles after qreq, held until done
    exp_q.push_back(2'b01);
    bus.req = 1'b1;
    wait_sig("norm_req_to_qreq", 0, 1'b1, 3);
    check("norm_busy", bus.busy, 1'b1);
    tick(2);
    bus.qack = 1'b1;
    tick(1);
    check("norm_hold_state", state_dbg, ST_HOLD);
    wait_sig("norm_qack_to_is0", 1, 1'b1, 4);
    wait_sig("norm_is0_to_qreq_low", 0, 1'b0, 8);
    check("norm_done", bus.done, 1'b1);
    check("norm_busy_at_done", bus.busy, 1'b1);
    check("norm_tout", bus.tout, 1'b0);
    bus.qack = 1'b0;
    tick(1);
    check("norm_done_low", bus.done, 1'b0);
    check("norm_busy_low", bus.busy, 1'b0);
    tick(3);
    check("norm_stays_idle", {bus.qreq, bus.busy, bus.is0}, 3'b001);

    // timeout
    do_reset(1'b0);
    exp_q.push_back(2'b11);
    bus.req = 1'b1;
    wait_sig("to_req_to_qreq", 0, 1'b1, 3);
    wait_sig("to_qreq_to_tout", 3, 1'b1, 16);
    check("to_hold_state", state_dbg, ST_HOLD);
    check("to_is0_before", bus.is0, 1'b0);
    wait_sig("to_hold_to_is0", 1, 1'b1, 4);
    wait_sig("to_is0_to_qreq_low", 0, 1'b0, 8);
    check("to_done", bus.done, 1'b1);
    tick(2);

    // request churn during hold, then back to 0 after the first sequence
    do_reset(1'b0);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b00);
    bus.req = 1'b1;
    wait_sig("churn_req_to_qreq", 0, 1'b1, 3);
    bus.qack = 1'b1;
    tick(1);
    bus.qack = 1'b0;
    bus.req  = 1'b0;
    tick(1);
    bus.req = 1'b1;
    wait_sig("churn_hold_to_is0", 1, 1'b1, 3);
    bus.req = 1'b0;
    wait_sig("churn_first_end", 0, 1'b0, 8);
    check("churn_first_done", {bus.done, bus.is0}, 2'b11);
    wait_sig("churn_gap", 0, 1'b1, 2);
    check("churn_second_tout", bus.tout, 1'b0);
    bus.qack = 1'b1;
    tick(1);
    bus.qack = 1'b0;
    wait_sig("churn_second_is0", 1, 1'b0, 4);
    wait_sig("churn_second_end", 0, 1'b0, 8);
    check("churn_second_done", {bus.done, bus.is0}, 2'b10);
    tick(2);

    // qack arrives on the edge the wait counter is exhausted
    do_reset(1'b0);
    bus.req = 1'b1;
    wait_sig("sim_req_to_qreq", 0, 1'b1, 3);
    tick(15);
    check("sim_still_waiting", {bus.tout, bus.is0, bus.qreq}, 3'b001);
    bus.qack = 1'b1;
    tick(1);
    bus.qack = 1'b0;
    check("sim_tout", bus.tout, 1'b0);
    check("sim_hold_state", state_dbg, ST_HOLD);
    exp_q.push_back(2'b01);
    wait_sig("sim_qack_to_is0", 1, 1'b1, 4);
    wait_sig("sim_is0_to_qreq_low", 0, 1'b0, 8);
    tick(2);

    // reset in the middle of settle
    do_reset(1'b0);
    bus.req = 1'b1;
    wait_sig("mid_req_to_qreq", 0, 1'b1, 3);
    bus.qack = 1'b1;
    tick(1);
    bus.qack = 1'b0;
    wait_sig("mid_qack_to_is0", 1, 1'b1, 4);
    tick(2);
    #3;
    rstn = 1'b0;
    #1;
    check("mid_async_clear", {bus.is0, bus.qreq, bus.busy, bus.done}, 4'b0000);
    check("mid_async_state", state_dbg, ST_IDLE);
    tick(3);
    rstn = 1'b1;
    exp_q.push_back(2'b01);
    wait_sig("mid_restart_qreq", 0, 1'b1, 3);
    bus.qack = 1'b1;
    tick(1);
    bus.qack = 1'b0;
    wait_sig("mid_restart_is0", 1, 1'b1, 4);
    wait_sig("mid_restart_end", 0, 1'b0, 8);
    check("mid_restart_done", bus.done, 1'b1);
    tick(4);

    check("scoreboard_drained", exp_q.size(), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gmux_sel_ctrl.md
# gmux_sel_ctrl

Single-clock sequencer that drives the select input (IS0) of the downstream GMUX clock multiplexer. It takes a level request for the desired clock source and asks the logic consuming the muxed clock to quiesce. It then waits through a programmable hold-off, flips the select, waits a settle period, releases the quiesce request and signals completion. It sits directly upstream of GMUX: its IS0 output connects 1:1 to the GMUX IS0 pin.

## Interface
- HOLD_CYCLES, 4: clock cycles between quiesce acknowledge (or timeout) and the IS0 change; range 1..2^CNT_W-1.
- SETTLE_CYCLES, 8: clock cycles IS0 is held stable before quiesce is released; range 1..2^CNT_W-1.
- TIMEOUT_CYCLES, 16: maximum cycles spent waiting for QACK; range 1..2^CNT_W-1.
- CNT_W, 8: width of the shared down-counter.
- CLK  in  1  sequencer clock; free-running, not the muxed clock.
- RSTN  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to CLK at the integration level.
- REQ  in  1  requested source level: 0 = IP, 1 = IC. May be asynchronous to CLK.
- QACK  in  1  consumer acknowledges quiesce; level, synchronous to CLK.
- IS0  out  1  select to GMUX; registered.
- QREQ  out  1  quiesce request to the clock consumer; registered.
- BUSY  out  1  high whenever the state is not IDLE.
- DONE  out  1  one-cycle pulse when a switch sequence completes.
- TOUT  out  1  sticky flag: the last sequence advanced on timeout, not on QACK.

## Operation
- REQ passes through a 2-flop synchronizer (REQ_S); no other input is synchronized.
- Reset (RSTN=0, asynchronous): state IDLE; IS0=0, QREQ=0, BUSY=0, DONE=0, TOUT=0; synchronizer flops=0; counter=0. A reset during any state aborts immediately and forces IS0 to 0.
- States: IDLE, QWAIT, HOLD, SETTLE, FIN.
- IDLE: if REQ_S != IS0, latch TGT=REQ_S, set QREQ=1, clear TOUT, load counter=TIMEOUT_CYCLES-1, go to QWAIT. If REQ_S == IS0, stay in IDLE.
- QWAIT: on QACK=1, load counter=HOLD_CYCLES-1 and go to HOLD. Otherwise, if counter==0, set TOUT=1, load HOLD_CYCLES-1 and go to HOLD. Otherwise decrement the counter.
- HOLD: decrement the counter. At counter==0, set IS0=TGT, load SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE: decrement the counter. At counter==0, set QREQ=0 and DONE=1, and go to FIN.
- FIN: DONE=0, go to IDLE. REQ_S is re-evaluated in IDLE on the next cycle.
- REQ changes while BUSY are ignored. TGT is fixed at sequence start. If REQ_S differs from the new IS0 when the sequence returns to IDLE, a new sequence starts; there is no abort.
- QACK in IDLE, HOLD, SETTLE or FIN is ignored. QACK and a timeout on the same edge: QACK wins, and TOUT stays 0.
- IS0 changes only on the HOLD→SETTLE edge. It never changes while QREQ=0, except on reset.
- Counter arithmetic is unsigned CNT_W bits and never underflows, because loads are parameter-1 values with minimum 0.

## Timing
- REQ edge to REQ_S: 2 CLK edges. REQ_S mismatch to QREQ=1 and BUSY=1: 1 edge.
- QACK sampled high to IS0 change: exactly HOLD_CYCLES edges.
- QWAIT with no QACK, counting from the edge QREQ rises:
  - TIMEOUT_CYCLES edges until HOLD is entered.
  - TOUT rises on that HOLD-entry edge.
- IS0 change to QREQ=0 and DONE=1: exactly SETTLE_CYCLES edges. DONE lasts 1 cycle. BUSY falls 1 edge after DONE.
- Minimum gap from one DONE to the next QREQ rise: 2 edges (FIN, then IDLE evaluation).
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
All scenarios use default parameters.

- Reset/idle: hold RSTN=0 with REQ=1, then release and keep REQ=0 for 50 cycles. Required: IS0=0, QREQ=0, BUSY=0 throughout.
- Normal switch: REQ 0→1; QACK rises 3 cycles after QREQ. Required:
  - QREQ rises 3 edges after REQ.
  - IS0=1 exactly 4 edges after QACK is sampled.
  - QREQ=0 and a 1-cycle DONE pulse 8 edges after IS0 rises.
  - TOUT=0.
- Timeout: REQ 0→1 with QACK held at 0. Required:
  - TOUT=1 and HOLD entered 16 edges after QREQ rises.
  - IS0=1 4 edges later.
  - DONE pulses 8 edges after that.
- Request churn: during HOLD, toggle REQ 1→0→1, and finish with REQ=0 once the first sequence completes. Required:
  - The first sequence completes with IS0=1.
  - A second sequence starts 2 edges after DONE and ends with IS0=0.
- Simultaneous events: QACK rises on the same edge the QWAIT counter reaches 0. Required: TOUT=0, and timing is as for the QACK path.
- Reset mid-operation: assert RSTN=0 during SETTLE with IS0=1. Required: IS0, QREQ, BUSY and DONE go to 0 without waiting for a CLK edge. After release with REQ=1, a full new sequence runs.
